riscv_aes_writeback: RTL and testbench
======================================

RISCV_AES_WRITEBACK -- requirements
Module: riscv_aes_writeback

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus, result word and address width.
REQ-002 SHALL have parameter NUM_WORDS, default 4, meaning result words stored per job.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port result_valid_i  input  1  one-cycle pulse; AES result and write-back address valid.
REQ-006 SHALL have port result_a_i/result_b_i/result_c_i/result_d_i  input  DATA_WIDTH each  result words 0..3.
REQ-007 SHALL have port wb_addr_i  input  DATA_WIDTH  destination base byte address.
REQ-008 SHALL have port data_req_o  output  1  bus request.
REQ-009 SHALL have port data_gnt_i  input  1  bus grant.
REQ-010 SHALL have port data_rvalid_i  input  1  write response.
REQ-011 SHALL have port data_err_i  input  1  bus error, qualified by data_rvalid_i.
REQ-012 SHALL have port data_addr_o  output  DATA_WIDTH  word address.
REQ-013 SHALL have port data_wdata_o  output  DATA_WIDTH  write data.
REQ-014 SHALL have port data_we_o  output  1  write enable.
REQ-015 SHALL have port data_be_o  output  4  byte enables.
REQ-016 SHALL have port busy_o  output  1  job in progress.
REQ-017 SHALL have port done_o  output  1  one-cycle job-complete pulse.
REQ-018 SHALL have port err_o  output  1  sticky error of the last job.
REQ-019 SHALL have port overrun_o  output  1  sticky flag for a dropped result.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, RESP, DONE.
REQ-021 SHALL, in IDLE on result_valid_i, capture all four words and wb_addr_i with bits [1:0] forced to 0, clear word index and err_o, and go to REQ the next cycle.
REQ-022 SHALL, in REQ, assert data_req_o=1, data_we_o=1, data_be_o=4'hF, data_addr_o=base+4*index, data_wdata_o=word[index], where word0=result_a, word1=result_b, word2=result_c, word3=result_d.
REQ-023 SHALL hold data_req_o, data_addr_o and data_wdata_o stable in REQ until data_gnt_i=1, and go to RESP on the grant cycle.
REQ-024 SHALL deassert data_req_o in RESP and allow at most one outstanding transaction.
REQ-025 SHALL, in RESP on data_rvalid_i, set err_o when data_err_i=1, then increment index and return to REQ, or go to DONE after word NUM_WORDS-1.
REQ-026 SHALL continue writing the remaining words after a bus error.
REQ-027 SHALL pulse done_o for exactly one cycle in DONE and return to IDLE on the next cycle.
REQ-028 SHALL compute address arithmetic modulo 2^DATA_WIDTH, so base 32'hFFFFFFF8 writes FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-029 SHALL drive busy_o=1 in REQ, RESP and DONE, and 0 in IDLE.
REQ-030 SHALL ignore result_valid_i outside IDLE, keep the captured data unchanged, and set overrun_o.
REQ-031 SHALL clear overrun_o only on reset.
REQ-032 SHALL ignore data_gnt_i outside REQ and data_rvalid_i outside RESP.
REQ-033 SHALL drive data_addr_o, data_wdata_o and data_be_o to 0 whenever data_req_o=0.
REQ-034 SHALL give a latency of 1 cycle from result_valid_i to the first data_req_o; with zero-wait grant and response, a job SHALL take 2*NUM_WORDS+2 cycles to done_o.

Reset
REQ-035 SHALL, on rst_n=0, asynchronously force IDLE, index 0, and captured words and address to 0.
REQ-036 SHALL, on rst_n=0, drive data_req_o=0, data_we_o=0, data_be_o=0, busy_o=0, done_o=0, err_o=0 and overrun_o=0.
REQ-037 SHALL abandon a job on reset mid-transaction without issuing further requests, including while a grant is pending.

Verification
REQ-038 SHALL cover a zero-wait job: base 32'h1000, words 11111111/22222222/33333333/44444444 -> writes to 1000/1004/1008/100C in order, done_o 10 cycles after valid, err_o=0.
REQ-039 SHALL cover grant stall: gnt held 0 for 5 cycles on word 1 -> req, addr 1004 and data 22222222 stable all 5 cycles, single write per word.
REQ-040 SHALL cover an error: data_err_i=1 on word 2 response -> word 3 still written, err_o=1 after done_o, cleared at next job start.
REQ-041 SHALL cover overrun: result_valid_i during RESP with different data -> original data written, overrun_o=1 until reset.
REQ-042 SHALL cover wrap and alignment: base 32'hFFFFFFFB -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-043 SHALL cover reset mid-job: rst_n low during REQ of word 1 -> data_req_o=0 immediately, busy_o=0, no done_o, and the next job runs normally.

Source files
------------

// File: rtl/riscv_aes_writeback.sv
`default_nettype none
// ============================================================================
// Module   : riscv_aes_writeback
// Brief    : Stores a captured AES result to memory, one word per bus write.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_aes_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  result_valid_i,
  input  logic [DATA_WIDTH-1:0] result_a_i,
  input  logic [DATA_WIDTH-1:0] result_b_i,
  input  logic [DATA_WIDTH-1:0] result_c_i,
  input  logic [DATA_WIDTH-1:0] result_d_i,
  input  logic [DATA_WIDTH-1:0] wb_addr_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic                  data_err_i,
  output logic [DATA_WIDTH-1:0] data_addr_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  overrun_o
);

  localparam int c_IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_WORDS - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0]            r_state;
  logic [c_IDX_W-1:0]    r_idx;
  logic [DATA_WIDTH-1:0] r_base;
  logic [DATA_WIDTH-1:0] r_words [NUM_WORDS];
  logic                  r_err;
  logic                  r_ovr;

  logic [DATA_WIDTH-1:0] w_in [NUM_WORDS];
  logic [DATA_WIDTH-1:0] w_offset;
  logic                  w_req;

  // Only four result ports exist; any extra slots capture zero.
  generate
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_in
      if (g == 0) begin : g_a
        assign w_in[g] = result_a_i;
      end else if (g == 1) begin : g_b
        assign w_in[g] = result_b_i;
      end else if (g == 2) begin : g_c
        assign w_in[g] = result_c_i;
      end else if (g == 3) begin : g_d
        assign w_in[g] = result_d_i;
      end else begin : g_zero
        assign w_in[g] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_idx   <= '0;
      r_base  <= '0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_words[i] <= '0;
      end
    end else begin
      if (result_valid_i && (r_state != c_IDLE)) begin
        r_ovr <= 1'b1;
      end
      case (r_state)
        c_IDLE: begin
          if (result_valid_i) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              r_words[i] <= w_in[i];
            end
            r_base  <= wb_addr_i & ~DATA_WIDTH'(3);
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_state <= c_REQ;
          end
        end
        c_REQ: begin
          if (data_gnt_i) begin
            r_state <= c_RESP;
          end
        end
        c_RESP: begin
          if (data_rvalid_i) begin
            if (data_err_i) begin
              r_err <= 1'b1;
            end
            // A failed write does not stop the job; remaining words still go out.
            if (r_idx == c_LAST) begin
              r_state <= c_DONE;
            end else begin
              r_idx   <= r_idx + c_IDX_W'(1);
              r_state <= c_REQ;
            end
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Bus outputs are decoded from state so reset drops the request at once.
  assign w_req    = (r_state == c_REQ);
  assign w_offset = DATA_WIDTH'({r_idx, 2'b00});

  assign data_req_o   = w_req;
  assign data_we_o    = w_req;
  assign data_be_o    = w_req ? 4'hF : 4'h0;
  assign data_addr_o  = w_req ? (r_base + w_offset) : '0;
  assign data_wdata_o = w_req ? r_words[r_idx] : '0;

  assign busy_o    = (r_state != c_IDLE);
  assign done_o    = (r_state == c_DONE);
  assign err_o     = r_err;
  assign overrun_o = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_riscv_aes_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_aes_writeback
// Brief    : Directed and randomized checks of the AES write-back block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_aes_writeback;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        result_valid_i = 1'b0;
  logic [31:0] result_a_i = '0;
  logic [31:0] result_b_i = '0;
  logic [31:0] result_c_i = '0;
  logic [31:0] result_d_i = '0;
  logic [31:0] wb_addr_i = '0;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic        data_err_i = 1'b0;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        overrun_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Bus slave knobs
  logic        rand_bus = 1'b0;
  logic        rand_err = 1'b0;
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] stall_addr = 32'hDEAD_0000;
  int          stall_len = 0;

  logic [63:0] wr_log [$];

  riscv_aes_writeback #(.DATA_WIDTH(32), .NUM_WORDS(NW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .result_valid_i (result_valid_i),
    .result_a_i     (result_a_i),
    .result_b_i     (result_b_i),
    .result_c_i     (result_c_i),
    .result_d_i     (result_d_i),
    .wb_addr_i      (wb_addr_i),
    .data_req_o     (data_req_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .data_err_i     (data_err_i),
    .data_addr_o    (data_addr_o),
    .data_wdata_o   (data_wdata_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: a job is a list of NW writes; counts of grants and
  // responses decide what the bus must show in each cycle.
  logic        m_active = 1'b0;
  logic [2:0]  m_gr = '0;
  logic [2:0]  m_rs = '0;
  logic        m_err = 1'b0;
  logic        m_ovr = 1'b0;
  logic [31:0] m_base = '0;
  logic [31:0] m_words [NW];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_gr     <= '0;
      m_rs     <= '0;
      m_err    <= 1'b0;
      m_ovr    <= 1'b0;
      m_base   <= '0;
      for (int i = 0; i < NW; i++) m_words[i] <= '0;
    end else if (!m_active) begin
      if (result_valid_i) begin
        m_active   <= 1'b1;
        m_gr       <= '0;
        m_rs       <= '0;
        m_err      <= 1'b0;
        m_base     <= wb_addr_i & 32'hFFFF_FFFC;
        m_words[0] <= result_a_i;
        m_words[1] <= result_b_i;
        m_words[2] <= result_c_i;
        m_words[3] <= result_d_i;
      end
    end else begin
      if (result_valid_i) m_ovr <= 1'b1;
      if (m_rs == 3'(NW)) begin
        m_active <= 1'b0;
      end else if (m_gr == m_rs) begin
        if (data_gnt_i) m_gr <= m_gr + 3'd1;
      end else if (data_rvalid_i) begin
        m_rs <= m_rs + 3'd1;
        if (data_err_i) m_err <= 1'b1;
      end
    end
  end

  logic        exp_req;
  logic        exp_done;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;
  assign exp_req  = m_active && (m_gr == m_rs) && (m_rs < 3'(NW));
  assign exp_done = m_active && (m_rs == 3'(NW));
  assign exp_addr = m_base + 32'(m_rs) * 32'd4;
  assign exp_data = m_words[m_rs[1:0]];

  always @(negedge clk) begin
    check("req",     32'(data_req_o), 32'(exp_req));
    check("busy",    32'(busy_o),     32'(m_active));
    check("done",    32'(done_o),     32'(exp_done));
    check("err",     32'(err_o),      32'(m_err));
    check("overrun", 32'(overrun_o),  32'(m_ovr));
    check("we",      32'(data_we_o),  32'(exp_req));
    check("be",      32'(data_be_o),  exp_req ? 32'hF : 32'h0);
    check("addr",    data_addr_o,     exp_req ? exp_addr : 32'h0);
    check("wdata",   data_wdata_o,    exp_req ? exp_data : 32'h0);
    if (rst_n && data_req_o && data_gnt_i) wr_log.push_back({data_addr_o, data_wdata_o});
  end

  // Bus slave: grants, responds once per grant, plus ignored noise.
  initial begin : slave
    logic        s_req;
    logic        s_out;
    logic [31:0] s_addr;
    logic [31:0] s_out_addr;
    int          s_stall;
    s_out = 1'b0;
    s_out_addr = '0;
    s_stall = 0;
    forever begin
      @(negedge clk);
      s_req  = data_req_o;
      s_addr = data_addr_o;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        s_out = 1'b0;
        s_stall = 0;
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i = 1'b0;
      end else begin
        if (s_req && data_gnt_i) begin
          s_out = 1'b1;
          s_out_addr = s_addr;
        end else if (s_out && data_rvalid_i) begin
          s_out = 1'b0;
        end
        if (s_out) begin
          data_rvalid_i = rand_bus ? ($urandom_range(0, 2) != 0) : 1'b1;
          data_err_i = data_rvalid_i && ((err_en && (s_out_addr == err_addr)) ||
                                         (rand_err && ($urandom_range(0, 4) == 0)));
        end else begin
          data_rvalid_i = rand_bus && ($urandom_range(0, 1) == 1);
          data_err_i = rand_bus && ($urandom_range(0, 1) == 1);
        end
        if (data_req_o) begin
          if ((data_addr_o == stall_addr) && (s_stall < stall_len)) begin
            data_gnt_i = 1'b0;
            s_stall++;
          end else begin
            data_gnt_i = rand_bus ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (data_gnt_i) s_stall = 0;
          end
        end else begin
          data_gnt_i = rand_bus && ($urandom_range(0, 1) == 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic job_start(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    result_a_i = w0;
    result_b_i = w1;
    result_c_i = w2;
    result_d_i = w3;
    wb_addr_i = base;
    result_valid_i = 1'b1;
    step();
    result_valid_i = 1'b0;
    result_a_i = $urandom;
    result_b_i = $urandom;
    result_c_i = $urandom;
    result_d_i = $urandom;
    wb_addr_i = $urandom;
  endtask

  task automatic wait_done(input logic noise, input logic [31:0] watch,
                           output int cycles, output int watch_cnt);
    cycles = 0;
    watch_cnt = 0;
    while (!done_o && cycles < 400) begin
      if (data_req_o && (data_addr_o == watch)) watch_cnt++;
      if (noise && ($urandom_range(0, 7) == 0)) begin
        result_valid_i = 1'b1;
        result_a_i = $urandom;
        wb_addr_i = $urandom;
      end else begin
        result_valid_i = 1'b0;
      end
      step();
      cycles++;
    end
    result_valid_i = 1'b0;
    check("done_seen", 32'(done_o), 32'd1);
  endtask

  task automatic check_writes(input int start, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] ea [NW];
    logic [31:0] ed [NW];
    ea = '{a0, a1, a2, a3};
    ed = '{d0, d1, d2, d3};
    check("write_count", 32'(wr_log.size() - start), 32'(NW));
    if (wr_log.size() - start == NW) begin
      for (int k = 0; k < NW; k++) begin
        check("write_addr", wr_log[start + k][63:32], ea[k]);
        check("write_data", wr_log[start + k][31:0], ed[k]);
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cyc;
    int wcnt;
    int start;

    #1 rst_n = 1'b0;
    repeat (3) step();
    check("rst_req",  32'(data_req_o), 32'd0);
    check("rst_busy", 32'(busy_o),     32'd0);
    check("rst_be",   32'(data_be_o),  32'd0);
    check("rst_ovr",  32'(overrun_o),  32'd0);
    rst_n = 1'b1;
    step();

    // Zero-wait job: 10 cycles counting the valid cycle and the done cycle.
    start = wr_log.size();
    job_start(32'h1000, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    check("first_req_latency", 32'(data_req_o), 32'd1);
    wait_done(1'b0, 32'hFFFF_FFFF, cyc, wcnt);
    check("job_cycles", 32'(cyc + 2), 32'd10);
    check("zw_err", 32'(err_o), 32'd0);
    check_writes(start, 32'h1000, 32'h1004, 32'h1008, 32'h100C,
                 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    step();

    // Grant withheld for 5 cycles on word 1.
    stall_addr = 32'h1004;
    stall_len = 5;
    start = wr_log.size();
    job_start(32'h1000, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3);
    wait_done(1'b0, 32'h1004, cyc, wcnt);
    check("stall_req_cycles", 32'(wcnt), 32'd6);
    check_writes(start, 32'h1000, 32'h1004, 32'h1008, 32'h100C,
                 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3);
    stall_len = 0;
    step();

    // Bus error on word 2.
    err_en = 1'b1;
    err_addr = 32'h1008;
    start = wr_log.size();
    job_start(32'h1000, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404);
    wait_done(1'b0, 32'hFFFF_FFFF, cyc, wcnt);
    check_writes(start, 32'h1000, 32'h1004, 32'h1008, 32'h100C,
                 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404);
    step();
    check("err_after_done", 32'(err_o), 32'd1);
    err_en = 1'b0;

    // Overrun during RESP; next job also shows err cleared on start.
    start = wr_log.size();
    job_start(32'h4000, 32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003);
    check("err_cleared", 32'(err_o), 32'd0);
    step();
    result_valid_i = 1'b1;
    result_a_i = 32'h55555555;
    wb_addr_i = 32'h8000;
    step();
    result_valid_i = 1'b0;
    check("overrun_set", 32'(overrun_o), 32'd1);
    wait_done(1'b0, 32'hFFFF_FFFF, cyc, wcnt);
    check_writes(start, 32'h4000, 32'h4004, 32'h4008, 32'h400C,
                 32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003);
    step();

    // Unaligned base wrapping past the top of the address space.
    start = wr_log.size();
    job_start(32'hFFFFFFFB, 32'h9, 32'h8, 32'h7, 32'h6);
    wait_done(1'b0, 32'hFFFF_FFFF, cyc, wcnt);
    check_writes(start, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004,
                 32'h9, 32'h8, 32'h7, 32'h6);
    check("overrun_sticky", 32'(overrun_o), 32'd1);
    step();

    // Reset while word 1 waits for a grant.
    stall_addr = 32'h2004;
    stall_len = 1000;
    job_start(32'h2000, 32'h1, 32'h2, 32'h3, 32'h4);
    cyc = 0;
    while (!(data_req_o && (data_addr_o == 32'h2004)) && cyc < 50) begin
      step();
      cyc++;
    end
    check("rst_reach_word1", 32'(data_req_o && (data_addr_o == 32'h2004)), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req",  32'(data_req_o), 32'd0);
    check("midrst_busy", 32'(busy_o),     32'd0);
    step();
    check("midrst_done", 32'(done_o), 32'd0);
    step();
    rst_n = 1'b1;
    stall_len = 0;
    check("overrun_cleared", 32'(overrun_o), 32'd0);
    step();
    start = wr_log.size();
    job_start(32'h3000, 32'h31, 32'h32, 32'h33, 32'h34);
    wait_done(1'b0, 32'hFFFF_FFFF, cyc, wcnt);
    check_writes(start, 32'h3000, 32'h3004, 32'h3008, 32'h300C,
                 32'h31, 32'h32, 32'h33, 32'h34);
    step();

    // Randomized jobs with random bus timing, errors and stray valids.
    rand_bus = 1'b1;
    rand_err = 1'b1;
    for (int j = 0; j < 40; j++) begin
      job_start($urandom, $urandom, $urandom, $urandom, $urandom);
      wait_done(1'b1, 32'hFFFF_FFFF, cyc, wcnt);
      step();
      if ($urandom_range(0, 1) == 1) step();
    end
    rand_bus = 1'b0;
    rand_err = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
